// File: rtl/t05_header_stream_pkg.sv
// Shared definitions for the t05 header bit streamer: default widths,
// command encodings and FSM state constants.
package t05_header_stream_pkg;

    localparam int DEF_CHAR_W = 8;
    localparam int DEF_CNT_W  = 8;
    localparam int DEF_TOT_W  = 16;

    typedef enum logic [1:0] {
        CMD_CHAR    = 2'b00,
        CMD_ZEROS   = 2'b01,
        CMD_LEFTS   = 2'b10,
        CMD_ILLEGAL = 2'b11
    } cmd_type_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EMIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/t05_header_stream_if.sv
// Command-in / serial-bit-out handshake bundle of the header streamer.
interface t05_header_stream_if #(
    parameter int CHAR_W = 8,
    parameter int CNT_W  = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_type;
    logic [CHAR_W-1:0] cmd_char;
    logic [CNT_W-1:0]  cmd_count;
    logic              bit_out;
    logic              bit_valid;
    logic              bit_ready;

    modport master (
        output cmd_valid, cmd_type, cmd_char, cmd_count, bit_ready,
        input  cmd_ready, bit_out, bit_valid
    );

    modport slave (
        input  cmd_valid, cmd_type, cmd_char, cmd_count, bit_ready,
        output cmd_ready, bit_out, bit_valid
    );
endinterface

// File: rtl/t05_piso_shift.sv
// Parallel-load shift register; the MSB is presented first and zeroes
// are shifted in from the bottom.
module t05_piso_shift #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] data_i,
    output logic         msb_o
);

    logic [W-1:0] sr_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sr_q <= '0;
        end else if (load_i) begin
            sr_q <= data_i;
        end else if (shift_i) begin
            sr_q <= {sr_q[W-2:0], 1'b0};
        end
    end

    assign msb_o = sr_q[W-1];

endmodule

// File: rtl/t05_header_stream.sv
// Serialises CHAR / ZEROS / LEFTS header commands into a valid/ready bit
// stream and keeps a running count of handed-off header bits.
module t05_header_stream
    import t05_header_stream_pkg::*;
#(
    parameter int CHAR_W = DEF_CHAR_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int TOT_W  = DEF_TOT_W
) (
    input  logic                 clk,
    input  logic                 nrst,
    t05_header_stream_if.slave   bus,
    input  logic                 clear,
    output logic                 rec_done,
    output logic                 busy,
    output logic [TOT_W-1:0]     hdr_bits,
    output logic                 err
);

    localparam int SH_W = 1 + ((CHAR_W > CNT_W) ? CHAR_W : CNT_W);
    localparam int BC_W = CNT_W + 1;

    logic [1:0]      state_q, state_d;
    logic [BC_W-1:0] left_q, left_d;
    logic [TOT_W-1:0] hdr_q, hdr_d;
    logic            err_q, err_d;
    logic            accept, handshake, load, msb;
    logic [SH_W-1:0] load_data;
    cmd_type_e       ctype;

    assign ctype     = cmd_type_e'(bus.cmd_type);
    assign accept    = bus.cmd_valid && bus.cmd_ready;
    assign handshake = bus.bit_valid && bus.bit_ready;

    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        left_d    = left_q;
        err_d     = err_q;
        load      = 1'b0;
        load_data = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (ctype)
                        CMD_CHAR: begin
                            load      = 1'b1;
                            load_data = SH_W'({1'b1, bus.cmd_char}) << (SH_W - 1 - CHAR_W);
                            left_d    = BC_W'(CHAR_W + 1);
                            state_d   = ST_EMIT;
                        end
                        CMD_ZEROS: begin
                            load    = 1'b1;
                            left_d  = {1'b0, bus.cmd_count};
                            state_d = (bus.cmd_count == '0) ? ST_DONE : ST_EMIT;
                        end
                        CMD_LEFTS: begin
                            load      = 1'b1;
                            load_data = SH_W'({1'b1, bus.cmd_count}) << (SH_W - 1 - CNT_W);
                            left_d    = BC_W'(CNT_W + 1);
                            state_d   = (bus.cmd_count == '0) ? ST_DONE : ST_EMIT;
                        end
                        default: begin
                            err_d   = 1'b1;
                            state_d = ST_DONE;
                        end
                    endcase
                end
            end
            ST_EMIT: begin
                if (handshake) begin
                    left_d = left_q - 1'b1;
                    if (left_q == BC_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Clear wins over an illegal command seen in the same cycle.
        if (clear) begin
            err_d = 1'b0;
        end
    end

    always_comb begin
        hdr_d = hdr_q;
        if (clear) begin
            hdr_d = '0;
        end else if (handshake) begin
            hdr_d = hdr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            left_q  <= '0;
            hdr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            left_q  <= left_d;
            hdr_q   <= hdr_d;
            err_q   <= err_d;
        end
    end

    t05_piso_shift #(.W(SH_W)) u_piso (
        .clk     (clk),
        .nrst    (nrst),
        .load_i  (load),
        .shift_i (handshake),
        .data_i  (load_data),
        .msb_o   (msb)
    );

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.bit_valid = (state_q == ST_EMIT);
    assign bus.bit_out   = bus.bit_valid & msb;
    assign rec_done      = (state_q == ST_DONE);
    assign busy          = (state_q != ST_IDLE);
    assign hdr_bits      = hdr_q;
    assign err           = err_q;

endmodule

// File: doc/t05_header_stream.md
T05_HEADER_STREAM -- requirements
Module: t05_header_stream

Interface
REQ-001 SHALL have parameter CHAR_W, default 8: character index width in bits.
REQ-002 SHALL have parameter CNT_W, default 8: width of the zero-run length and num_lefts fields.
REQ-003 SHALL have parameter TOT_W, default 16: width of the running header bit counter.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-005 SHALL have port nrst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port cmd_valid, input, 1 bit: a command is offered.
REQ-007 SHALL have port cmd_ready, output, 1 bit: the block can accept a command.
REQ-008 SHALL have port cmd_type, input, 2 bits: 00 CHAR, 01 ZEROS, 10 LEFTS, 11 illegal.
REQ-009 SHALL have port cmd_char, input, CHAR_W bits: the character index for a CHAR command.
REQ-010 SHALL have port cmd_count, input, CNT_W bits: the zero-run length for ZEROS, or num_lefts for LEFTS.
REQ-011 SHALL have port bit_out, output, 1 bit: the serial header bit.
REQ-012 SHALL have port bit_valid, output, 1 bit: bit_out is valid.
REQ-013 SHALL have port bit_ready, input, 1 bit: the downstream consumer takes bit_out.
REQ-014 SHALL have port rec_done, output, 1 bit: one-cycle pulse marking the end of a record.
REQ-015 SHALL have port busy, output, 1 bit: a record is in progress.
REQ-016 SHALL have port hdr_bits, output, TOT_W bits: total header bits handed off since reset or clear.
REQ-017 SHALL have port err, output, 1 bit: sticky flag for an illegal command.
REQ-018 SHALL have port clear, input, 1 bit: synchronous clear of hdr_bits and err.

Function
REQ-019 SHALL accept a command when cmd_valid && cmd_ready; cmd_ready = (state == IDLE).
REQ-020 SHALL implement states IDLE, EMIT and DONE; state encoding is free.
REQ-021 SHALL, on accepting CHAR, load the frame {1'b1, cmd_char} (CHAR_W+1 bits) and emit it MSB first.
REQ-022 SHALL, on accepting ZEROS, emit cmd_count bits of value 0.
REQ-023 SHALL, on accepting LEFTS, emit the frame {1'b1, cmd_count} (CNT_W+1 bits) MSB first.
REQ-024 SHALL place the first bit of a record on bit_out with bit_valid=1 in the cycle after acceptance (latency 1).
REQ-025 SHALL hold bit_out and bit_valid stable until bit_ready=1; a bit is handed off only on the cycle bit_valid && bit_ready.
REQ-026 SHALL sustain one bit per cycle while bit_ready=1, with no bubbles inside a record.
REQ-027 SHALL go EMIT→DONE on the handshake of the record's last bit, and DONE→IDLE after one cycle.
REQ-028 SHALL assert rec_done for exactly the one cycle spent in DONE.
REQ-029 SHALL go IDLE→DONE directly for ZEROS or LEFTS with cmd_count=0: no bits emitted, rec_done still pulses.
REQ-030 SHALL go IDLE→DONE for an illegal type: no bits, err set to 1, rec_done pulses.
REQ-031 SHALL keep bit_valid=0 in IDLE and DONE.
REQ-032 SHALL drive busy = (state != IDLE).
REQ-033 SHALL increment hdr_bits by 1 on every bit handshake, wrapping modulo 2^TOT_W.
REQ-034 SHALL give clear priority over an increment in the same cycle; clear SHALL NOT affect an in-progress record.
REQ-035 SHALL hold the shift register width at 1+max(CHAR_W,CNT_W) and the bit counter width at CNT_W+1, with no overflow at cmd_count = 2^CNT_W−1.
REQ-036 SHALL capture cmd_* fields only at acceptance; later changes to the inputs SHALL be ignored.

Reset
REQ-037 SHALL, while nrst=0, immediately force state=IDLE and drive bit_valid=0, bit_out=0, rec_done=0, busy=0, hdr_bits=0, err=0, and cmd_ready=1 once nrst=1.
REQ-038 SHALL, when reset occurs mid-record, abandon the record without emitting a rec_done pulse.

Structure
REQ-039 SHALL take the cmd_type encodings and the state enum from the shared t05 package; the default widths SHALL live in the same package.
REQ-040 SHALL be written as one module; the only natural sub-module is t05_piso_shift (parallel-load, MSB-first shift register with load and shift enables).

Verification
REQ-041 SHALL cover: CHAR 0x41 with bit_ready=1 → bits 1,0,1,0,0,0,0,0,1 on 9 consecutive cycles starting 1 cycle after acceptance; rec_done 1 cycle after the last bit; hdr_bits=9.
REQ-042 SHALL cover: ZEROS count=3, then LEFTS count=5 → 0,0,0 then 1,0,0,0,0,0,1,0,1; two rec_done pulses; hdr_bits=12.
REQ-043 SHALL cover: CHAR 0xFF with bit_ready toggling every cycle → each bit held stable while stalled; 18 cycles of bit output; the sequence is unchanged.
REQ-044 SHALL cover: ZEROS count=0, LEFTS count=0 and type 11 → no bit_valid; three rec_done pulses; err=1 after type 11; clear → err=0, hdr_bits=0.
REQ-045 SHALL cover: nrst pulsed low after the 4th bit of a CHAR → all outputs reset asynchronously with no rec_done; the next CHAR serialises correctly.
REQ-046 SHALL cover: CHAR_W=10, CNT_W=4, ZEROS count=15 → 15 zeroes; CHAR 0x3FF → 11 ones.
